aes_result_collector: RTL and testbench
=======================================

Name: aes_result_collector

Overview:
Receiving end of the aes_engine output stream. Every cycle it samples the engine's out/out_type pair and buffers each valid result (ENCRYPT or DECRYPT) in a FIFO. Results are presented to a downstream consumer through a valid/ready handshake. It raises halt_req back to the engine before the FIFO can overflow, keeping in-flight pipeline results safe, and keeps per-type result counters.

Parameters:
DEPTH, 16, FIFO entries; power of two, must exceed SLACK
SLACK, 12, free entries reserved for results already in the engine pipeline; halt_req threshold = DEPTH - SLACK
CNT_W, 16, width of the enc_cnt/dec_cnt counters

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous active-low reset
eng_out  input  128  aes_engine out data
eng_out_type  input  job_t  aes_engine out_type; INVALID means no result this cycle
halt_req  output  1  connect to aes_engine halt; requests pipeline stall
res_valid  output  1  head entry available
res_ready  input  1  consumer accepts head entry
res_data  output  128  head entry data
res_type  output  job_t  head entry type (ENCRYPT/DECRYPT)
count  output  $clog2(DEPTH)+1  current occupancy
overflow  output  1  sticky: a valid result was dropped
clr_overflow  input  1  clears overflow
enc_cnt  output  CNT_W  ENCRYPT results accepted into FIFO
dec_cnt  output  CNT_W  DECRYPT results accepted into FIFO

Behaviour:
- Clock is clk; reset is rst_n, synchronous and active-low, sampled on posedge clk.
- Reset values: count=0, res_valid=0, halt_req=0, overflow=0, enc_cnt=0, dec_cnt=0, read/write pointers=0.
- Reset values of res_data and res_type are don't-care. The FIFO storage array is not reset.
- Push: when eng_out_type is ENCRYPT or DECRYPT, write {eng_out, eng_out_type} at wr_ptr on posedge clk. Any other encoding, including INVALID, is ignored.
- Pop: occurs when res_valid && res_ready; rd_ptr advances.
- res_valid = (count != 0). res_data and res_type are driven from the entry at rd_ptr.
- Latency: a result pushed at edge N is visible on res_* after edge N (1 cycle), including the fall-through case from empty.
- Empty with push but no pop in the same cycle: legal; entry becomes visible next cycle.
- Full (count==DEPTH) with push and no pop: entry is dropped and overflow is set. count and counters are unchanged.
- Full with push and pop in the same cycle: push is accepted. count stays DEPTH, pointers both advance, no overflow.
- Pointers wrap modulo DEPTH. count tracks push-only +1, pop-only -1, both or neither unchanged.
- halt_req = (count >= DEPTH-SLACK), combinational from the count register. It deasserts as soon as pops bring count below the threshold.
- Counters increment on each accepted push of their type and wrap at 2^CNT_W. Dropped results do not count.
- Setting overflow has priority over clr_overflow in the same cycle.
- Reset asserted mid-stream: all state returns to reset values at that edge. Buffered entries are lost and the next valid input is pushed normally after release.
- res_data/res_type must be held stable while res_valid && !res_ready.
- No state machine beyond FIFO occupancy. Compute the next count and full/empty from registered pointers, not from res_ready combinationally into halt_req.

Optional Feature:
AES_RESULT_SEQ_EN
- Defined:
  - Adds output res_seq [7:0].
  - An 8-bit sequence counter (reset 0) is stored with each accepted push and increments per accepted push, wrapping 255->0.
  - Dropped results do not consume a number.
  - The consumer can detect gaps after an overflow.
- Undefined:
  - res_seq port and the counter are absent.
  - The FIFO entry is 128+job_t bits wide.

Test Plan:
1. Reset, then one ENCRYPT push of eng_out=69c4e0d86a7b0430d8cdb78070b4c55a with res_ready=0 -> next cycle res_valid=1, res_data=69c4..c55a, res_type=ENCRYPT, count=1, enc_cnt=1. Data stays stable until res_ready=1 pops it, then count=0.
2. Alternate ENCRYPT/DECRYPT/INVALID inputs for 9 cycles with res_ready=1 -> 6 results emerge in order with matching types, enc_cnt=3, dec_cnt=3, INVALID cycles produce nothing.
3. Push 4 results with res_ready=0 (DEPTH=16, SLACK=12) -> halt_req rises the cycle count reaches 4. Pop one -> halt_req falls when count=3.
4. Fill to 16 with res_ready=0, push a 17th -> count=16, overflow=1, counters=16 total. Then push and pop in the same cycle -> accepted, no change to overflow. clr_overflow -> overflow=0.
5. Fill with 5 entries, assert rst_n=0 for one cycle while a push is present -> count=0, res_valid=0, enc_cnt=0, overflow=0. The next push after release appears alone.
6. With AES_RESULT_SEQ_EN, push 258 results while draining, forcing one overflow drop mid-run -> res_seq runs 0..255,0,1 with no gap at the drop, and the dropped result is absent.

Source files
------------

// File: rtl/aes_result_collector.sv
// -----------------------------------------------------------------------------
// aes_result_collector
//
// Receiving end of the aes_engine output stream. Each cycle the engine's
// out/out_type pair is sampled; ENCRYPT and DECRYPT results are buffered in a
// DEPTH-entry FIFO and offered to a consumer over a valid/ready handshake.
// halt_req stalls the engine once occupancy reaches DEPTH-SLACK so results
// already inside the engine pipeline still have room to land.
//
// Parameters:
//   DEPTH  FIFO entries (power of two, > SLACK)
//   SLACK  free entries reserved for in-flight engine results
//   CNT_W  width of enc_cnt / dec_cnt
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   eng_out, eng_out_type   engine result data / type (INVALID = no result)
//   halt_req                stall request back to the engine
//   res_valid/ready/data/type  consumer handshake and head entry
//   count                   current occupancy
//   overflow, clr_overflow  sticky drop flag and its clear
//   enc_cnt, dec_cnt        accepted results per type (wrapping)
//   res_seq                 sequence number of head entry (AES_RESULT_SEQ_EN)
//
// Optional feature macro: AES_RESULT_SEQ_EN
//   When defined, every accepted result is tagged with an 8-bit sequence
//   number so the consumer can spot gaps left by dropped results.
// -----------------------------------------------------------------------------

package aes_result_collector_pkg;

   typedef enum logic [1:0] {
      INVALID = 2'd0,
      ENCRYPT = 2'd1,
      DECRYPT = 2'd2
   } job_t;

   typedef struct packed {
      logic [127:0] data;
      job_t         typ;
`ifdef AES_RESULT_SEQ_EN
      logic [7:0]   seq;
`endif
   } entry_t;

endpackage

module aes_result_collector
   import aes_result_collector_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int SLACK = 12,
   parameter int CNT_W = 16
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [127:0]               eng_out,
   input  job_t                       eng_out_type,
   output logic                       halt_req,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [127:0]               res_data,
   output job_t                       res_type,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       overflow,
   input  logic                       clr_overflow,
   output logic [CNT_W-1:0]           enc_cnt,
   output logic [CNT_W-1:0]           dec_cnt
`ifdef AES_RESULT_SEQ_EN
   ,output logic [7:0]                res_seq
`endif
);

   localparam int            AW       = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   HALT_LVL = (AW+1)'(DEPTH - SLACK);

   // Storage is intentionally not reset; validity is tracked by count_q.
   entry_t           mem_q [DEPTH];

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             overflow_q, overflow_d;
   logic [CNT_W-1:0] enc_cnt_q, enc_cnt_d;
   logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
`ifdef AES_RESULT_SEQ_EN
   logic [7:0]       seq_q, seq_d;
`endif

   logic             push_req, pop, full, push_acc, drop;
   entry_t           wr_entry, rd_entry;

   always_comb begin
      push_req = (eng_out_type == ENCRYPT) || (eng_out_type == DECRYPT);
      pop      = (count_q != '0) && res_ready;
      full     = (count_q == FULL_LVL);
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      push_acc = push_req && (!full || pop);
      drop     = push_req && full && !pop;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_d = rd_ptr_q + 1'b1;

      count_d = count_q;
      case ({push_acc, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      // A new drop wins over a clear requested in the same cycle.
      overflow_d = overflow_q;
      if (drop)              overflow_d = 1'b1;
      else if (clr_overflow) overflow_d = 1'b0;

      enc_cnt_d = enc_cnt_q;
      dec_cnt_d = dec_cnt_q;
      if (push_acc && (eng_out_type == ENCRYPT)) enc_cnt_d = enc_cnt_q + 1'b1;
      if (push_acc && (eng_out_type == DECRYPT)) dec_cnt_d = dec_cnt_q + 1'b1;

      wr_entry      = '0;
      wr_entry.data = eng_out;
      wr_entry.typ  = eng_out_type;
`ifdef AES_RESULT_SEQ_EN
      // Only accepted results consume a number; drops leave no gap here,
      // the gap is visible as missing data downstream.
      wr_entry.seq  = seq_q;
      seq_d         = push_acc ? seq_q + 8'd1 : seq_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         enc_cnt_q  <= '0;
         dec_cnt_q  <= '0;
`ifdef AES_RESULT_SEQ_EN
         seq_q      <= '0;
`endif
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         enc_cnt_q  <= enc_cnt_d;
         dec_cnt_q  <= dec_cnt_d;
`ifdef AES_RESULT_SEQ_EN
         seq_q      <= seq_d;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && push_acc) mem_q[wr_ptr_q] <= wr_entry;
   end

   // Head entry is read asynchronously so a push into an empty FIFO is
   // visible one cycle later without an extra output register.
   assign rd_entry  = mem_q[rd_ptr_q];
   assign res_data  = rd_entry.data;
   assign res_type  = rd_entry.typ;
`ifdef AES_RESULT_SEQ_EN
   assign res_seq   = rd_entry.seq;
`endif

   assign res_valid = (count_q != '0);
   assign halt_req  = (count_q >= HALT_LVL);
   assign count     = count_q;
   assign overflow  = overflow_q;
   assign enc_cnt   = enc_cnt_q;
   assign dec_cnt   = dec_cnt_q;

endmodule

// File: tb/tb_aes_result_collector.sv
module tb_aes_result_collector;
   import aes_result_collector_pkg::*;

   logic         clk = 1'b0;
   logic         rst_n;
   logic [127:0] eng_out;
   job_t         eng_out_type;
   logic         halt_req;
   logic         res_valid;
   logic         res_ready;
   logic [127:0] res_data;
   job_t         res_type;
   logic [4:0]   count;
   logic         overflow;
   logic         clr_overflow;
   logic [15:0]  enc_cnt;
   logic [15:0]  dec_cnt;
`ifdef AES_RESULT_SEQ_EN
   logic [7:0]   res_seq;
`endif

   int checks   = 0;
   int failures = 0;

   aes_result_collector #(.DEPTH(16), .SLACK(12), .CNT_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .eng_out      (eng_out),
      .eng_out_type (eng_out_type),
      .halt_req     (halt_req),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_data     (res_data),
      .res_type     (res_type),
      .count        (count),
      .overflow     (overflow),
      .clr_overflow (clr_overflow),
      .enc_cnt      (enc_cnt),
      .dec_cnt      (dec_cnt)
`ifdef AES_RESULT_SEQ_EN
      ,.res_seq     (res_seq)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n        = 1'b0;
      eng_out      = '0;
      eng_out_type = INVALID;
      res_ready    = 1'b0;
      clr_overflow = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic push(input job_t t, input logic [127:0] d);
      eng_out_type = t;
      eng_out      = d;
   endtask

   initial begin
      job_t               typ;
      logic [129:0]       exp_q [$];
      logic [129:0]       e;
      int                 got;

      // ---- reset state
      do_reset();
      chk("rst_count", count, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_halt", halt_req, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_enc", enc_cnt, 0);
      chk("rst_dec", dec_cnt, 0);

      // ---- 1: single ENCRYPT, held until accepted
      push(ENCRYPT, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      step();
      push(INVALID, '0);
      chk("t1_valid", res_valid, 1);
      chk("t1_data", res_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      chk("t1_type", res_type, ENCRYPT);
      chk("t1_count", count, 1);
      chk("t1_enc", enc_cnt, 1);
      step();
      chk("t1_hold", res_data, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      res_ready = 1'b1;
      step();
      chk("t1_popcnt", count, 0);
      chk("t1_popvld", res_valid, 0);
      res_ready = 1'b0;

      // ---- 2: E/D/I stream with consumer always ready
      do_reset();
      res_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 9; i++) begin
         case (i % 3)
            0:       typ = ENCRYPT;
            1:       typ = DECRYPT;
            default: typ = INVALID;
         endcase
         push(typ, 128'h1000 + 128'(i));
         if (typ != INVALID) exp_q.push_back({128'h1000 + 128'(i), typ});
         step();
         chk("t2_valid", res_valid, (typ != INVALID));
         if (res_valid && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("t2_data", res_data, e[129:2]);
            chk("t2_type", res_type, e[1:0]);
            got++;
         end
      end
      push(INVALID, '0);
      step();
      chk("t2_got", got, 6);
      chk("t2_enc", enc_cnt, 3);
      chk("t2_dec", dec_cnt, 3);
      chk("t2_count", count, 0);
      res_ready = 1'b0;

      // ---- 3: halt_req threshold at DEPTH-SLACK = 4
      do_reset();
      for (int i = 0; i < 4; i++) begin
         push(ENCRYPT, 128'h3000 + 128'(i));
         step();
         chk("t3_count", count, i + 1);
         chk("t3_halt", halt_req, (i == 3));
      end
      push(INVALID, '0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("t3_popcnt", count, 3);
      chk("t3_halt_fall", halt_req, 0);

      // ---- 4: fill, overflow, push+pop at full, clear priority, wrap drain
      do_reset();
      for (int i = 0; i < 16; i++) begin
         push((i % 2 == 0) ? ENCRYPT : DECRYPT, 128'h4000 + 128'(i));
         step();
      end
      chk("t4_full", count, 16);
      chk("t4_ovf0", overflow, 0);
      chk("t4_halt", halt_req, 1);
      push(ENCRYPT, 128'hdead);
      step();
      chk("t4_cnt_drop", count, 16);
      chk("t4_ovf1", overflow, 1);
      chk("t4_enc", enc_cnt, 8);
      chk("t4_dec", dec_cnt, 8);
      chk("t4_head", res_data, 128'h4000);
      push(DECRYPT, 128'h4010);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("t4_pp_cnt", count, 16);
      chk("t4_pp_ovf", overflow, 1);
      chk("t4_pp_head", res_data, 128'h4001);
      chk("t4_pp_dec", dec_cnt, 9);
      push(ENCRYPT, 128'hbeef);
      clr_overflow = 1'b1;
      step();
      chk("t4_set_prio", overflow, 1);
      chk("t4_enc_drop", enc_cnt, 8);
      push(INVALID, '0);
      step();
      clr_overflow = 1'b0;
      chk("t4_clr", overflow, 0);
      res_ready = 1'b1;
      for (int j = 0; j < 16; j++) begin
         chk("t4_drain", res_data, (j < 15) ? 128'h4001 + 128'(j) : 128'h4010);
         step();
      end
      res_ready = 1'b0;
      chk("t4_empty", count, 0);

      // ---- 5: reset mid-stream
      do_reset();
      for (int i = 0; i < 5; i++) begin
         push(ENCRYPT, 128'h5000 + 128'(i));
         step();
      end
      chk("t5_count5", count, 5);
      rst_n = 1'b0;
      push(ENCRYPT, 128'h5555);
      step();
      chk("t5_rcount", count, 0);
      chk("t5_rvalid", res_valid, 0);
      chk("t5_renc", enc_cnt, 0);
      chk("t5_rovf", overflow, 0);
      chk("t5_rhalt", halt_req, 0);
      rst_n = 1'b1;
      push(ENCRYPT, 128'h7777);
      step();
      chk("t5_count1", count, 1);
      chk("t5_data", res_data, 128'h7777);
      chk("t5_enc1", enc_cnt, 1);
      push(INVALID, '0);
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      chk("t5_alone", count, 0);

`ifdef AES_RESULT_SEQ_EN
      // ---- 6: sequence numbers across a drop
      begin
         logic [127:0] mq [$];
         logic [7:0]   exp_seq;
         int           accepted, n, popped;
         bit           dropped, pop_now, full_before, do_push, accept;
         do_reset();
         exp_seq  = 8'd0;
         accepted = 0;
         n        = 0;
         popped   = 0;
         dropped  = 1'b0;
         for (int cyc = 0; cyc < 2000; cyc++) begin
            if (accepted >= 258 && mq.size() == 0) break;
            do_push   = (accepted < 258);
            res_ready = dropped;
            if (do_push) push(ENCRYPT, 128'h6000 + 128'(n));
            else         push(INVALID, '0);
            pop_now     = res_ready && (mq.size() > 0);
            full_before = (mq.size() == 16);
            accept      = do_push && (!full_before || pop_now);
            chk("t6_valid", res_valid, (mq.size() > 0));
            if (pop_now) begin
               chk("t6_data", res_data, mq.pop_front());
               chk("t6_seq", res_seq, exp_seq);
               exp_seq = exp_seq + 8'd1;
               popped++;
            end
            if (accept) begin
               mq.push_back(128'h6000 + 128'(n));
               accepted++;
            end else if (do_push) begin
               dropped = 1'b1;
            end
            if (do_push) n++;
            step();
         end
         res_ready = 1'b0;
         chk("t6_popped", popped, 258);
         chk("t6_seq_end", exp_seq, 8'd2);
         chk("t6_ovf", overflow, 1);
         chk("t6_empty", count, 0);
      end
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
